snake_input_ctrl: RTL and testbench
===================================

# snake_input_ctrl

Input-side conditioner for the snake game: synchronizes and debounces the five raw push-buttons and emits a one-cycle Ack pulse. It also turns direction presses into a registered heading that the game step consumes. It sits between the board buttons and snake_core, where it replaces the raw BtnL/BtnR/BtnU/BtnD/BtnC wiring. A pending-direction buffer holds the latest legal request until the next game Tick commits it, so the snake never reverses onto itself.

## Interface
- DB_CYCLES, default 250000: consecutive cycles a synchronized input must differ from its debounced level before the level flips. Legal range is 2 to 2^24-1.
- Clk  in  1  board clock; the only clock.
- Reset  in  1  asynchronous, active-high; clears all state.
- BtnU, BtnR, BtnD, BtnL, BtnC  in  1 each  raw, asynchronous push-buttons.
- Tick  in  1  one-Clk-cycle strobe, once per snake move.
- Enable  in  1  high while the game is in play.
- Btn_Db  out  5  debounced levels, bit order {C,L,D,R,U} (bit0 = U).
- Ack_Pulse  out  1  one-cycle pulse per debounced BtnC press.
- Dir  out  2  committed heading: 00 Up, 01 Right, 10 Down, 11 Left.
- Pend_Valid  out  1  a requested heading is waiting for Tick.
- Pend_Dir  out  2  the waiting heading; meaningful only when Pend_Valid = 1.

## Operation
- Reset values: Btn_Db = 0, Ack_Pulse = 0, Dir = 01 (Right), Pend_Valid = 0, Pend_Dir = 01. All counters and synchronizers are 0.
- Synchronizer: each button passes through a 2-flop synchronizer.
- Debounce, per button:
  - A counter of width clog2(DB_CYCLES) increments while the synced input differs from Btn_Db.
  - The counter clears whenever the synced input equals Btn_Db.
  - When the counter is at DB_CYCLES-1 and the input still differs, Btn_Db toggles and the counter clears.
- Press event: the registered rising edge of a Btn_Db bit (0 -> 1). Releases produce no event.
- Ack_Pulse: asserted for exactly one cycle on a BtnC press event. It is independent of Enable.
- Same-cycle direction presses: priority U > R > D > L. Only one candidate is considered per cycle.
- Legality: a candidate is legal when it is neither the reference heading nor its opposite (opposite = bit1 inverted).
  - Reference heading = Dir, except in a Tick cycle with Pend_Valid = 1, where it is Pend_Dir.
- Pending FSM, states IDLE (Pend_Valid = 0) and PEND (Pend_Valid = 1):
  - IDLE, legal candidate, no Tick: Pend_Dir <= candidate, go to PEND.
  - PEND, legal candidate: Pend_Dir <= candidate (last wins), stay in PEND.
  - PEND, candidate equal to Dir: pending cancelled, go to IDLE.
  - PEND, candidate opposite to Dir: ignored.
  - PEND, Tick: Dir <= Pend_Dir, go to IDLE.
  - Tick and candidate in the same cycle: commit first, then evaluate the candidate against the newly committed heading. If legal, the candidate becomes pending (end in PEND).
  - IDLE, Tick with no candidate: no change.
- Enable = 0 forces Dir <= 01, Pend_Valid <= 0, Pend_Dir <= 01 every cycle. Direction events are discarded. Debounce continues running.
- Reset asserted mid-debounce or mid-pending returns everything to the reset values. No pulse is emitted on deassertion, even with a button held: a held button needs a full debounce interval before it registers.

## Timing
- Raw input steady from cycle 0: the synced value appears at cycle 2.
- Btn_Db flips at cycle 2 + DB_CYCLES.
- Ack_Pulse, and any Pend_Valid/Pend_Dir update, occur at cycle 3 + DB_CYCLES.
- A bounce shorter than DB_CYCLES cycles (after sync) produces no change.
- Tick sampled high at edge t: Dir updates at t+1. Pend_Valid falls at t+1 unless a same-cycle candidate was accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
Sim parameter DB_CYCLES = 4.
- Reset, then hold BtnC high for 20 cycles -> Btn_Db[4] rises at cycle 6, Ack_Pulse high only at cycle 7, and no further pulse while held.
- BtnU toggling every 2 cycles for 30 cycles, then released low -> Btn_Db stays 0, Pend_Valid stays 0.
- Dir = Right, press Left -> rejected, Pend_Valid = 0. Then press Up -> Pend_Valid = 1, Pend_Dir = 00. Then Tick -> Dir = 00 next cycle, Pend_Valid = 0.
- Dir = Right, press Up, then Down before Tick -> Pend_Dir = 10 (last wins). Then press Right -> pending cancelled, Pend_Valid = 0.
- Dir = Right, Pend = Up, Tick in the same cycle as a Left press event -> Dir = 00 and Pend_Dir = 11 with Pend_Valid = 1. A Down press event in the same situation is rejected, ending in Dir = 00 and Pend_Valid = 0.
- Pend_Valid = 1, then Enable dropped (or Reset asserted mid-debounce) -> Dir = 01, Pend_Valid = 0 next cycle (Reset: immediately), and Ack_Pulse = 0.

Source files
------------

// File: rtl/snake_input_ctrl.sv
// Button conditioner for the snake game: 2-flop sync, per-button debounce, press
// edge detection, Ack pulse on BtnC and a Tick-committed pending heading buffer.
module snake_input_ctrl #(
    parameter int DB_CYCLES = 250000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnR,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnC,
    input  logic       Tick,
    input  logic       Enable,
    output logic [4:0] Btn_Db,
    output logic       Ack_Pulse,
    output logic [1:0] Dir,
    output logic       Pend_Valid,
    output logic [1:0] Pend_Dir
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic {IDLE, PEND} state_t;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {~d[1], d[0]};
    endfunction

    logic [4:0]    raw;
    logic [4:0]    sync_p0, sync_p1;
    logic [CW-1:0] cnt   [5];
    logic [CW-1:0] cnt_n [5];
    logic [4:0]    db_n;
    logic [4:0]    db_p2;
    logic [4:0]    rise;

    state_t        state, state_n;
    logic [1:0]    dir_n, pend_n;
    logic          cand_valid;
    logic [1:0]    cand;
    logic          commit;
    logic [1:0]    ref_dir;
    logic          legal;

    assign raw = {BtnC, BtnL, BtnD, BtnR, BtnU};

    // Stage p0/p1: two-flop synchronizer
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    always_comb begin
        db_n = Btn_Db;
        for (int i = 0; i < 5; i++) begin
            cnt_n[i] = '0;
            if (sync_p1[i] != Btn_Db[i]) begin
                if (cnt[i] == CNT_MAX) db_n[i] = ~Btn_Db[i];
                else                   cnt_n[i] = cnt[i] + CW'(1);
            end
        end
    end

    // Stage p2: debounced level, its delayed copy for edge detection, Ack
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
            Btn_Db    <= '0;
            db_p2     <= '0;
            Ack_Pulse <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) cnt[i] <= cnt_n[i];
            Btn_Db    <= db_n;
            db_p2     <= Btn_Db;
            Ack_Pulse <= rise[4];
        end
    end

    assign rise = Btn_Db & ~db_p2;

    always_comb begin
        cand_valid = |rise[3:0];
        if      (rise[0]) cand = DIR_UP;
        else if (rise[1]) cand = DIR_RIGHT;
        else if (rise[2]) cand = DIR_DOWN;
        else              cand = DIR_LEFT;
    end

    // A Tick with a pending heading commits first; the candidate is judged against that.
    assign commit  = Tick && (state == PEND);
    assign ref_dir = commit ? Pend_Dir : Dir;
    assign legal   = cand_valid && (cand != ref_dir) && (cand != opposite(ref_dir));

    always_comb begin
        state_n = state;
        dir_n   = Dir;
        pend_n  = Pend_Dir;
        if (!Enable) begin
            state_n = IDLE;
            dir_n   = DIR_RIGHT;
            pend_n  = DIR_RIGHT;
        end else begin
            if (commit) begin
                dir_n   = Pend_Dir;
                state_n = IDLE;
            end
            if (legal) begin
                pend_n  = cand;
                state_n = PEND;
            end else if ((state == PEND) && !Tick && cand_valid && (cand == Dir)) begin
                state_n = IDLE;
            end
        end
    end

    // Stage p3: committed heading and pending buffer
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            Dir      <= DIR_RIGHT;
            Pend_Dir <= DIR_RIGHT;
        end else begin
            state    <= state_n;
            Dir      <= dir_n;
            Pend_Dir <= pend_n;
        end
    end

    assign Pend_Valid = (state == PEND);

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DB_CYCLES = 4.
module tb_snake_input_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       BtnU = 1'b0, BtnR = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnC = 1'b0;
    logic       Tick = 1'b0;
    logic       Enable = 1'b0;
    logic [4:0] Btn_Db;
    logic       Ack_Pulse;
    logic [1:0] Dir;
    logic       Pend_Valid;
    logic [1:0] Pend_Dir;

    int checks = 0;
    int failures = 0;

    snake_input_ctrl #(.DB_CYCLES(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .BtnU(BtnU), .BtnR(BtnR), .BtnD(BtnD), .BtnL(BtnL), .BtnC(BtnC),
        .Tick(Tick), .Enable(Enable),
        .Btn_Db(Btn_Db), .Ack_Pulse(Ack_Pulse), .Dir(Dir),
        .Pend_Valid(Pend_Valid), .Pend_Dir(Pend_Dir)
    );

    always #5 Clk = ~Clk;

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: BtnU = v;
            1: BtnR = v;
            2: BtnD = v;
            3: BtnL = v;
            default: BtnC = v;
        endcase
    endtask

    // Press and release one button; optional Tick lands in the press-event cycle.
    task automatic press(input int b, input logic with_tick);
        bit seen;
        set_btn(b, 1'b1);
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge Clk);
            if (Btn_Db[b] === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL press_timeout btn=%0d Btn_Db=%b expected bit high", b, Btn_Db);
        end
        Tick = with_tick;
        @(negedge Clk);
        Tick = 1'b0;
        set_btn(b, 1'b0);
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge Clk);
            if (Btn_Db[b] === 1'b0) seen = 1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL release_timeout btn=%0d Btn_Db=%b expected bit low", b, Btn_Db);
        end
        @(negedge Clk);
    endtask

    task automatic en_clear();
        Enable = 1'b0;
        @(negedge Clk);
        Enable = 1'b1;
        @(negedge Clk);
    endtask

    task automatic check_state(input string name, input logic [1:0] e_dir,
                               input logic e_pv, input logic [1:0] e_pd);
        checks++;
        if (Dir !== e_dir) begin
            failures++;
            $display("FAIL %s_dir got=%b exp=%b", name, Dir, e_dir);
        end
        checks++;
        if (Pend_Valid !== e_pv) begin
            failures++;
            $display("FAIL %s_pv got=%b exp=%b", name, Pend_Valid, e_pv);
        end
        if (e_pv) begin
            checks++;
            if (Pend_Dir !== e_pd) begin
                failures++;
                $display("FAIL %s_pd got=%b exp=%b", name, Pend_Dir, e_pd);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        checks++;
        if ({Btn_Db, Ack_Pulse, Dir, Pend_Valid, Pend_Dir} !== {5'b0, 1'b0, 2'b01, 1'b0, 2'b01}) begin
            failures++;
            $display("FAIL reset_values got=%b_%b_%b_%b_%b exp=00000_0_01_0_01",
                     Btn_Db, Ack_Pulse, Dir, Pend_Valid, Pend_Dir);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_ack_hold();
        BtnC = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk); #1;
            checks++;
            if (Btn_Db !== ((k >= 6) ? 5'b10000 : 5'b00000)) begin
                failures++;
                $display("FAIL ack_hold_db cycle=%0d got=%b exp=%b", k, Btn_Db,
                         (k >= 6) ? 5'b10000 : 5'b00000);
            end
            checks++;
            if (Ack_Pulse !== (k == 7)) begin
                failures++;
                $display("FAIL ack_hold_pulse cycle=%0d got=%b exp=%b", k, Ack_Pulse, (k == 7));
            end
        end
        @(negedge Clk);
        BtnC = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            checks++;
            if (Ack_Pulse !== 1'b0) begin
                failures++;
                $display("FAIL ack_release cycle=%0d got=%b exp=0", k, Ack_Pulse);
            end
        end
        checks++;
        if (Btn_Db !== 5'b0) begin
            failures++;
            $display("FAIL ack_release_db got=%b exp=00000", Btn_Db);
        end
    endtask

    task automatic test_bounce();
        Enable = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            checks++;
            if (Btn_Db !== 5'b0 || Pend_Valid !== 1'b0) begin
                failures++;
                $display("FAIL bounce cycle=%0d db=%b pv=%b exp db=00000 pv=0", k, Btn_Db, Pend_Valid);
            end
            BtnU = ((k / 2) % 2 == 0);
        end
        BtnU = 1'b0;
        repeat (10) @(negedge Clk);
        checks++;
        if (Btn_Db !== 5'b0 || Pend_Valid !== 1'b0) begin
            failures++;
            $display("FAIL bounce_end db=%b pv=%b exp db=00000 pv=0", Btn_Db, Pend_Valid);
        end
    endtask

    task automatic test_dir_commit();
        en_clear();
        press(3, 1'b0);
        check_state("left_reject", 2'b01, 1'b0, 2'b01);
        press(0, 1'b0);
        check_state("up_pend", 2'b01, 1'b1, 2'b00);
        Tick = 1'b1;
        @(negedge Clk);
        Tick = 1'b0;
        check_state("tick_commit", 2'b00, 1'b0, 2'b00);
    endtask

    task automatic test_last_wins();
        en_clear();
        check_state("en_clear", 2'b01, 1'b0, 2'b01);
        press(0, 1'b0);
        press(2, 1'b0);
        check_state("last_wins", 2'b01, 1'b1, 2'b10);
        press(1, 1'b0);
        check_state("cancel", 2'b01, 1'b0, 2'b01);
    endtask

    task automatic test_tick_same_cycle();
        en_clear();
        press(0, 1'b0);
        check_state("same_pend", 2'b01, 1'b1, 2'b00);
        press(3, 1'b1);
        check_state("same_left", 2'b00, 1'b1, 2'b11);
        en_clear();
        press(0, 1'b0);
        press(2, 1'b1);
        check_state("same_down", 2'b00, 1'b0, 2'b00);
    endtask

    task automatic test_enable_drop();
        en_clear();
        press(0, 1'b0);
        check_state("pre_drop", 2'b01, 1'b1, 2'b00);
        Enable = 1'b0;
        @(negedge Clk);
        check_state("enable_drop", 2'b01, 1'b0, 2'b01);
        checks++;
        if (Pend_Dir !== 2'b01 || Ack_Pulse !== 1'b0) begin
            failures++;
            $display("FAIL enable_drop_pd_ack pd=%b ack=%b exp pd=01 ack=0", Pend_Dir, Ack_Pulse);
        end
        Enable = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        press(0, 1'b0);
        check_state("pre_reset", 2'b01, 1'b1, 2'b00);
        BtnC = 1'b1;
        repeat (4) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        check_state("reset_mid", 2'b01, 1'b0, 2'b01);
        checks++;
        if (Btn_Db !== 5'b0 || Ack_Pulse !== 1'b0 || Pend_Dir !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid_outs db=%b ack=%b pd=%b exp db=00000 ack=0 pd=01",
                     Btn_Db, Ack_Pulse, Pend_Dir);
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge Clk); #1;
            checks++;
            if (Ack_Pulse !== (k == 7) || Btn_Db[4] !== (k >= 6)) begin
                failures++;
                $display("FAIL reset_rearm cycle=%0d ack=%b db4=%b exp ack=%b db4=%b",
                         k, Ack_Pulse, Btn_Db[4], (k == 7), (k >= 6));
            end
        end
        @(negedge Clk);
        BtnC = 1'b0;
        repeat (10) @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_ack_hold();
        test_bounce();
        test_dir_commit();
        test_last_wins();
        test_tick_same_cycle();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
